// File: rtl/fsm_seq_pkg.sv
// Shared encodings for fsm_sequencer: command/response codes, controller states,
// the controlled unit's Status constants and small decode helpers.
package fsm_seq_pkg;

    typedef enum logic [1:0] {
        OP_CYCLE = 2'd0,
        OP_PARK  = 2'd1,
        OP_RESET = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        RSP_OK       = 2'd0,
        RSP_TIMEOUT  = 2'd1,
        RSP_PROTOCOL = 2'd2,
        RSP_ILLEGAL  = 2'd3
    } rsp_e;

    // Every state that can end an op fits in three bits; RESP is never reported.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RST      = 4'd1,
        ST_WAIT_S1  = 4'd2,
        ST_ADV_S2   = 4'd3,
        ST_ADV_S3   = 4'd4,
        ST_EXIT     = 4'd5,
        ST_PARK     = 4'd6,
        ST_PARK_CHK = 4'd7,
        ST_RESP     = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        OBS_S1    = 3'd0,
        OBS_S2    = 3'd1,
        OBS_S3    = 3'd2,
        OBS_QUIET = 3'd3,
        OBS_BAD   = 3'd4
    } obs_e;

    localparam logic [2:0] IDLE_ST = 3'b000;
    localparam logic [2:0] S2_ST   = 3'b010;
    localparam logic [2:0] S3_ST   = 3'b011;

    function automatic obs_e decode_unit(input logic o1, input logic o2, input logic [2:0] status);
        obs_e obs;
        if (o1 && !o2 && status == IDLE_ST)        obs = OBS_S1;
        else if (o1 && o2 && status == S2_ST)      obs = OBS_S2;
        else if (!o1 && !o2 && status == S3_ST)    obs = OBS_S3;
        else if (!o1 && !o2 && status == IDLE_ST)  obs = OBS_QUIET;
        else                                       obs = OBS_BAD;
        return obs;
    endfunction

    // {A, B} driven to the unit while the controller sits in a given state.
    function automatic logic [1:0] unit_ab(input state_e st);
        logic [1:0] ab;
        case (st)
            ST_ADV_S2, ST_ADV_S3: ab = 2'b11;
            ST_EXIT:              ab = 2'b01;
            ST_PARK:              ab = 2'b10;
            default:              ab = 2'b00;
        endcase
        return ab;
    endfunction

    function automatic logic [2:0] phase_of(input state_e st);
        logic [2:0] ph;
        case (st)
            ST_RST:      ph = 3'd1;
            ST_WAIT_S1:  ph = 3'd2;
            ST_ADV_S2:   ph = 3'd3;
            ST_ADV_S3:   ph = 3'd4;
            ST_EXIT:     ph = 3'd5;
            ST_PARK:     ph = 3'd6;
            ST_PARK_CHK: ph = 3'd7;
            default:     ph = 3'd0;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/fsm_seq_timer.sv
// Phase timer for fsm_sequencer: counts cycles spent in the current state,
// cleared on state change; expired flags the last allowed cycle.
module fsm_seq_timer #(
    parameter int TIMER_W = 8,
    parameter int LIMIT   = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               clr,
    input  logic               en,
    output logic [TIMER_W-1:0] count,
    output logic               expired
);

    logic [TIMER_W-1:0] count_d, count_q;

    // Next count: clear wins over enable.
    always_comb begin
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + TIMER_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign expired = (count_q == TIMER_W'(LIMIT - 1));

endmodule

// File: rtl/fsm_sequencer.sv
// Command-driven controller walking the five-state sequence unit through CYCLE/PARK/RESET.
// Optional response counters ok_count/err_count are built when FSMSEQ_STATS_EN is defined.
module fsm_sequencer
    import fsm_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RESET_CYCLES   = 1,
    parameter int TIMER_W        = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [1:0] rsp_code,
    output logic [2:0] rsp_phase,
    output logic       busy,
    output logic       unit_reset,
    output logic       unit_a,
    output logic       unit_b,
    input  logic       unit_output1,
    input  logic       unit_output2,
    input  logic [2:0] unit_status
`ifdef FSMSEQ_STATS_EN
    ,
    output logic [15:0] ok_count,
    output logic [15:0] err_count
`endif
);

    localparam logic [TIMER_W-1:0] RST_LAST = TIMER_W'(RESET_CYCLES - 1);

    state_e     state_d, state_q, next_s;
    op_e        op_d, op_q;
    rsp_e       code_d, code_q;
    logic [2:0] phase_d, phase_q;
    logic       rsp_valid_d, rsp_valid_q, cmd_ready_d, cmd_ready_q, busy_d, busy_q;
    logic [1:0] ab_d, ab_q;
    obs_e       obs_s, want_s, allow_s;
    logic       is_wait_s, tmr_expired_s;
    logic [TIMER_W-1:0] tmr_count_s;

    assign obs_s = decode_unit(unit_output1, unit_output2, unit_status);

    // Per wait state: the awaited observation, the one tolerated meanwhile, and the successor.
    always_comb begin
        is_wait_s = 1'b0;
        want_s    = OBS_BAD;
        allow_s   = OBS_BAD;
        next_s    = ST_RESP;
        case (state_q)
            ST_WAIT_S1: begin is_wait_s = 1'b1; want_s = OBS_S1;    allow_s = OBS_QUIET; next_s = ST_ADV_S2;   end
            ST_ADV_S2:  begin is_wait_s = 1'b1; want_s = OBS_S2;    allow_s = OBS_S1;    next_s = ST_ADV_S3;   end
            ST_ADV_S3:  begin
                is_wait_s = 1'b1; want_s = OBS_S3; allow_s = OBS_S2;
                next_s    = (op_q == OP_PARK) ? ST_PARK : ST_EXIT;
            end
            ST_EXIT:    begin is_wait_s = 1'b1; want_s = OBS_QUIET; allow_s = OBS_S3;    next_s = ST_RESP;     end
            ST_PARK:    begin is_wait_s = 1'b1; want_s = OBS_QUIET; allow_s = OBS_S3;    next_s = ST_PARK_CHK; end
            default:    begin is_wait_s = 1'b0; end
        endcase
    end

    // Next-state, response capture and registered-output decode.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        code_d  = code_q;
        phase_d = phase_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d = op_e'(cmd_op);
                    if (op_e'(cmd_op) == OP_RSVD) begin
                        state_d = ST_RESP; code_d = RSP_ILLEGAL; phase_d = phase_of(state_q);
                    end else begin
                        state_d = ST_RST;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RST: begin
                if (tmr_count_s == RST_LAST) begin
                    if (op_q == OP_RESET) begin
                        state_d = ST_RESP; code_d = RSP_OK; phase_d = phase_of(state_q);
                    end else begin
                        state_d = ST_WAIT_S1;
                    end
                end else begin
                    state_d = ST_RST;
                end
            end
            ST_WAIT_S1, ST_ADV_S2, ST_ADV_S3, ST_EXIT, ST_PARK: begin
                // Protocol violations take priority over an expiring timer.
                if (obs_s == want_s) begin
                    state_d = next_s;
                    if (next_s == ST_RESP) begin
                        code_d = RSP_OK; phase_d = phase_of(state_q);
                    end else begin
                        code_d = code_q;
                    end
                end else if (obs_s != allow_s) begin
                    state_d = ST_RESP; code_d = RSP_PROTOCOL; phase_d = phase_of(state_q);
                end else if (tmr_expired_s) begin
                    state_d = ST_RESP; code_d = RSP_TIMEOUT; phase_d = phase_of(state_q);
                end else begin
                    state_d = state_q;
                end
            end
            ST_PARK_CHK: begin
                state_d = ST_RESP;
                phase_d = phase_of(state_q);
                if (obs_s == OBS_QUIET) begin
                    code_d = RSP_OK;
                end else begin
                    code_d = RSP_PROTOCOL;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rsp_valid_d = (state_d == ST_RESP);
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        ab_d        = unit_ab(state_d);
    end

    fsm_seq_timer #(
        .TIMER_W (TIMER_W),
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timer (
        .Clock   (Clock),
        .Reset   (Reset),
        .clr     (state_d != state_q),
        .en      (is_wait_s || (state_q == ST_RST)),
        .count   (tmr_count_s),
        .expired (tmr_expired_s)
    );

    // Controller state and registered outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_CYCLE;
            code_q      <= RSP_OK;
            phase_q     <= 3'd0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            ab_q        <= 2'b00;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            code_q      <= code_d;
            phase_q     <= phase_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            ab_q        <= ab_d;
        end
    end

    // The unit is reset alongside the controller, including mid-operation.
    assign unit_reset = Reset | (state_q == ST_RST);
    assign unit_a     = ab_q[1];
    assign unit_b     = ab_q[0];
    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_code   = code_q;
    assign rsp_phase  = phase_q;
    assign busy       = busy_q;

`ifdef FSMSEQ_STATS_EN
    logic [15:0] ok_count_d, ok_count_q, err_count_d, err_count_q;

    // Saturating outcome counters, stepped on the response handshake.
    always_comb begin
        ok_count_d  = ok_count_q;
        err_count_d = err_count_q;
        if (rsp_valid_q && rsp_ready) begin
            if (code_q == RSP_OK) begin
                ok_count_d = (ok_count_q != 16'hFFFF) ? ok_count_q + 16'd1 : ok_count_q;
            end else begin
                err_count_d = (err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
            end
        end else begin
            ok_count_d  = ok_count_q;
            err_count_d = err_count_q;
        end
    end

    // Counter registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ok_count_q  <= 16'd0;
            err_count_q <= 16'd0;
        end else begin
            ok_count_q  <= ok_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign ok_count  = ok_count_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_fsm_sequencer.sv
// Bench for fsm_sequencer: behavioural unit model with fault modes, outcome predictor
// from the sequencing rules, directed then randomized ops. Define FSMSEQ_STATS_EN to check counters.
module tb_fsm_sequencer;
    import fsm_seq_pkg::*;

    localparam int RC = 1;
    localparam int TO = 16;
    localparam int M_NORMAL = 0, M_STUCK = 1, M_GLITCH = 2, M_DEAD = 3, M_FALL = 4;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       rsp_ready = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic       cmd_ready, rsp_valid, busy, unit_reset, unit_a, unit_b;
    logic [1:0] rsp_code;
    logic [2:0] rsp_phase;
    logic       unit_output1, unit_output2;
    logic [2:0] unit_status;
`ifdef FSMSEQ_STATS_EN
    logic [15:0] ok_count, err_count;
`endif

    int errors = 0;
    int checks = 0;
    int mode = M_NORMAL;
    int u_st = 0;     // 0=Initial, 1..4 = S1..S4
    int exp_ok = 0;
    int exp_err = 0;

    fsm_sequencer dut (
        .Clock(Clock), .Reset(Reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_code(rsp_code), .rsp_phase(rsp_phase),
        .busy(busy), .unit_reset(unit_reset), .unit_a(unit_a), .unit_b(unit_b),
        .unit_output1(unit_output1), .unit_output2(unit_output2), .unit_status(unit_status)
`ifdef FSMSEQ_STATS_EN
        , .ok_count(ok_count), .err_count(err_count)
`endif
    );

    always #5 Clock = ~Clock;

    // Sequence unit model; mode selects a conforming unit or one of its faults.
    always @(posedge Clock) begin
        if (unit_reset) begin
            u_st <= 0;
        end else begin
            case (u_st)
                0: if (mode != M_DEAD) u_st <= 1;
                1: if (unit_a && unit_b && mode != M_STUCK) u_st <= 2;
                2: if (unit_a && unit_b) u_st <= 3;
                3: begin
                    if (!unit_a && unit_b) u_st <= 0;
                    else if (unit_a && !unit_b) u_st <= (mode == M_FALL) ? 0 : 4;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        unit_output1 = 1'b0;
        unit_output2 = 1'b0;
        unit_status  = 3'd0;
        case (u_st)
            1: unit_output1 = 1'b1;
            2: begin unit_output1 = 1'b1; unit_output2 = 1'b1; unit_status = 3'd2; end
            3: unit_status = 3'd3;
            default: ;
        endcase
        if (mode == M_GLITCH && u_st == 3 && unit_a && unit_b) begin
            unit_output1 = 1'b0;
            unit_output2 = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected outcome from the dwell time in each phase (cycles counted from the accept cycle).
    function automatic void predict(input int op, input int md, output int code, output int phase,
                                    output int lat, output int ab);
        int w0;
        w0 = 1 + RC;  // first WAIT_S1 cycle; unit leaves Initial one cycle later
        code = 0; phase = 0; lat = 0; ab = 0;
        if (op == 3) begin
            code = 3; phase = int'(ST_IDLE); lat = 1;
        end else if (op == 2) begin
            code = 0; phase = int'(ST_RST); lat = w0;
        end else if (md == M_DEAD) begin
            code = 1; phase = int'(ST_WAIT_S1); lat = w0 + TO;
        end else if (md == M_STUCK) begin
            code = 1; phase = int'(ST_ADV_S2); lat = w0 + 2 + TO; ab = TO;
        end else if (md == M_GLITCH) begin
            code = 2; phase = int'(ST_ADV_S3); lat = w0 + 2 + 2 + 1; ab = 3;
        end else if (op == 0) begin
            code = 0; phase = int'(ST_EXIT); lat = w0 + 2 + 2 + 1 + 2; ab = 3;
        end else if (md == M_FALL) begin
            code = 2; phase = int'(ST_PARK_CHK); lat = w0 + 2 + 2 + 1 + 2 + 1; ab = 3;
        end else begin
            code = 0; phase = int'(ST_PARK_CHK); lat = w0 + 2 + 2 + 1 + 2 + 1; ab = 3;
        end
    endfunction

    task automatic run_op(input int op, input int md, input int hold);
        int e_code, e_phase, e_lat, e_ab, lat, ab_n, rst_n;
        predict(op, md, e_code, e_phase, e_lat, e_ab);
        mode = md;
        chk("ready_idle", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        @(negedge Clock);
        cmd_valid = 1'b0;
        lat = 1; ab_n = 0; rst_n = 0;
        while (!rsp_valid && lat < 200) begin
            if (unit_a && unit_b) ab_n++;
            if (unit_reset) rst_n++;
            @(negedge Clock);
            lat++;
        end
        chk("latency", lat, e_lat);
        chk("rsp_code", 32'(rsp_code), e_code);
        chk("rsp_phase", 32'(rsp_phase), e_phase);
        chk("ab_cycles", ab_n, e_ab);
        chk("unit_reset_cycles", rst_n, (op == 3) ? 0 : RC);
        if (op == 0 && (md == M_NORMAL || md == M_FALL))
            chk("unit_ends_s1", 32'({unit_output1, unit_output2, unit_status}), 32'(5'b10000));
        for (int i = 0; i < hold; i++) begin
            @(negedge Clock);
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_code", 32'(rsp_code), e_code);
            chk("hold_phase", 32'(rsp_phase), e_phase);
            chk("hold_ready", 32'(cmd_ready), 0);
            if (op == 1 && md == M_NORMAL) begin
                chk("park_quiet", 32'({unit_output1, unit_output2, unit_status}), 0);
                chk("park_no_reset", 32'(unit_reset), 0);
            end
        end
        rsp_ready = 1'b1;
        @(negedge Clock);
        rsp_ready = 1'b0;
        if (e_code == 0) exp_ok++; else exp_err++;
        chk("rsp_dropped", 32'(rsp_valid), 0);
        chk("ready_back", 32'(cmd_ready), 1);
        chk("busy_clear", 32'(busy), 0);
`ifdef FSMSEQ_STATS_EN
        chk("ok_count", 32'(ok_count), exp_ok);
        chk("err_count", 32'(err_count), exp_err);
`endif
    endtask

    initial begin
        int n;
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_code", 32'(rsp_code), 0);
        chk("rst_phase", 32'(rsp_phase), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_unit_reset", 32'(unit_reset), 1);
        chk("rst_ab", 32'({unit_a, unit_b}), 0);
        Reset = 1'b0;
        @(negedge Clock);

        run_op(0, M_NORMAL, 0);
        run_op(1, M_NORMAL, 5);
        run_op(0, M_STUCK, 1);
        run_op(0, M_GLITCH, 0);
        run_op(3, M_NORMAL, 5);
        run_op(2, M_NORMAL, 0);
        run_op(1, M_FALL, 2);
        run_op(1, M_GLITCH, 0);
        run_op(0, M_DEAD, 0);

        // Reset while the controller is in ADV_S2.
        mode = M_NORMAL;
        cmd_valid = 1'b1;
        cmd_op = 2'd0;
        @(negedge Clock);
        cmd_valid = 1'b0;
        n = 0;
        while (!(unit_a && unit_b) && n < 50) begin
            @(negedge Clock);
            n++;
        end
        chk("midrst_reached", 32'({unit_a, unit_b}), 3);
        Reset = 1'b1;
        #1;
        chk("midrst_unit_reset", 32'(unit_reset), 1);
        @(negedge Clock);
        Reset = 1'b0;
        exp_ok = 0;
        exp_err = 0;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_valid", 32'(rsp_valid), 0);
        chk("midrst_ready", 32'(cmd_ready), 1);
        chk("midrst_ab", 32'({unit_a, unit_b}), 0);
`ifdef FSMSEQ_STATS_EN
        chk("midrst_ok_count", 32'(ok_count), 0);
        chk("midrst_err_count", 32'(err_count), 0);
`endif

        for (int k = 0; k < 30; k++) begin
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $fatal(1, "FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    end

endmodule
